// File: rtl/execute_stage_if.sv
// execute_stage_if: bundles the ID/EX-side signals, the forwarding paths
// and the EX/MEM outputs of the execute stage.
//
// Handshake: id_valid acts as "valid" and ~stall acts as "ready". The
// instruction in ID/EX retires (upstream may advance) on a rising edge where
// id_valid && !stall. A multiply/divide is captured by the engine on its
// first cycle, but stall holds ID/EX until the engine's DONE cycle, so it
// retires only once.
//
// Signals:
//   id_valid, alu_op, rs1, rs2, rs1_data, rs2_data, imm, use_imm, rd,
//   regwrite, mem_to_reg, mem_read, mem_write      : ID/EX register contents
//   fwd_mem_rd/data/regwrite, fwd_wb_rd/data/regwrite : forwarding sources
//   stall      : hold ID/EX and earlier stages
//   ex_mem     : {mem_to_reg, regwrite, mem_write, mem_read, result,
//                 store_data, rd}
//   fsm_state  : current execute-stage FSM state (debug visibility)
interface execute_stage_if #(
    parameter int XLEN = 32
);
    logic              id_valid;
    logic [3:0]        alu_op;
    logic [4:0]        rs1;
    logic [4:0]        rs2;
    logic [XLEN-1:0]   rs1_data;
    logic [XLEN-1:0]   rs2_data;
    logic [XLEN-1:0]   imm;
    logic              use_imm;
    logic [4:0]        rd;
    logic              regwrite;
    logic              mem_to_reg;
    logic              mem_read;
    logic              mem_write;
    logic [4:0]        fwd_mem_rd;
    logic [XLEN-1:0]   fwd_mem_data;
    logic              fwd_mem_regwrite;
    logic [4:0]        fwd_wb_rd;
    logic [XLEN-1:0]   fwd_wb_data;
    logic              fwd_wb_regwrite;
    logic              stall;
    logic [2*XLEN+8:0] ex_mem;
    logic [1:0]        fsm_state;

    modport master (
        output id_valid, alu_op, rs1, rs2, rs1_data, rs2_data, imm, use_imm,
               rd, regwrite, mem_to_reg, mem_read, mem_write,
               fwd_mem_rd, fwd_mem_data, fwd_mem_regwrite,
               fwd_wb_rd, fwd_wb_data, fwd_wb_regwrite,
        input  stall, ex_mem, fsm_state
    );

    modport slave (
        input  id_valid, alu_op, rs1, rs2, rs1_data, rs2_data, imm, use_imm,
               rd, regwrite, mem_to_reg, mem_read, mem_write,
               fwd_mem_rd, fwd_mem_data, fwd_mem_regwrite,
               fwd_wb_rd, fwd_wb_data, fwd_wb_regwrite,
        output stall, ex_mem, fsm_state
    );
endinterface

// File: rtl/execute_stage.sv
// execute_stage: EX stage of the 5-stage pipeline.
//   - Forwards operands from the memory-stage and writeback results.
//   - Single-cycle ALU (add/sub/logic/shifts/compares).
//   - Iterative multiply (shift-add) and unsigned divide (restoring), one
//     step per cycle over MD_CYCLES cycles, stalling upstream meanwhile.
//   - Registers the ex_mem bundle for the memory stage.
// Ports:
//   clk  : clock
//   rst  : asynchronous, active-high reset
//   ex   : execute_stage_if.slave (ID/EX inputs, forwarding, stall, ex_mem,
//          fsm_state debug output)
module execute_stage #(
    parameter int XLEN      = 32,
    parameter int MD_CYCLES = 32
) (
    input  logic            clk,
    input  logic            rst,
    execute_stage_if.slave  ex
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int CW = (MD_CYCLES > 1) ? $clog2(MD_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(MD_CYCLES - 1);

    state_t state, state_nx;
    logic   stall_c;

    logic [XLEN-1:0]   fwd_a, fwd_b, op_b, alu_r;
    logic              is_md;

    // Multiply/divide engine. acc holds {high, low}:
    //   multiply: {partial product high, remaining multiplier bits}
    //   divide  : {remainder, quotient bits shifted in from the dividend}
    logic [2*XLEN-1:0] acc, acc_step;
    logic [XLEN-1:0]   md_b;
    logic [CW-1:0]     cnt;
    logic              l_div, l_hi;
    logic [3:0]        l_ctrl;
    logic [XLEN-1:0]   l_store;
    logic [4:0]        l_rd;
    logic [2*XLEN+8:0] ex_mem_q;

    // ---------------- forwarding (memory stage has priority) ---------------
    always_comb begin
        fwd_a = ex.rs1_data;
        if (ex.fwd_mem_regwrite && ex.fwd_mem_rd != 5'd0 && ex.fwd_mem_rd == ex.rs1)
            fwd_a = ex.fwd_mem_data;
        else if (ex.fwd_wb_regwrite && ex.fwd_wb_rd != 5'd0 && ex.fwd_wb_rd == ex.rs1)
            fwd_a = ex.fwd_wb_data;
    end

    always_comb begin
        fwd_b = ex.rs2_data;
        if (ex.fwd_mem_regwrite && ex.fwd_mem_rd != 5'd0 && ex.fwd_mem_rd == ex.rs2)
            fwd_b = ex.fwd_mem_data;
        else if (ex.fwd_wb_regwrite && ex.fwd_wb_rd != 5'd0 && ex.fwd_wb_rd == ex.rs2)
            fwd_b = ex.fwd_wb_data;
    end

    assign op_b  = ex.use_imm ? ex.imm : fwd_b;
    assign is_md = (ex.alu_op >= 4'd10) && (ex.alu_op <= 4'd13);

    // ---------------- single-cycle ALU --------------------------------------
    always_comb begin
        alu_r = '0;
        case (ex.alu_op)
            4'd0:    alu_r = fwd_a + op_b;
            4'd1:    alu_r = fwd_a - op_b;
            4'd2:    alu_r = fwd_a & op_b;
            4'd3:    alu_r = fwd_a | op_b;
            4'd4:    alu_r = fwd_a ^ op_b;
            4'd5:    alu_r = fwd_a << op_b[4:0];
            4'd6:    alu_r = fwd_a >> op_b[4:0];
            4'd7:    alu_r = $unsigned($signed(fwd_a) >>> op_b[4:0]);
            4'd8:    alu_r = {{(XLEN-1){1'b0}}, ($signed(fwd_a) < $signed(op_b))};
            4'd9:    alu_r = {{(XLEN-1){1'b0}}, (fwd_a < op_b)};
            default: alu_r = '0;  // MD ops take the engine path; 14/15 reserved
        endcase
    end

    // ---------------- one engine step ---------------------------------------
    logic [XLEN:0]   mul_sum;
    logic [XLEN:0]   rem_sh;
    logic [XLEN-1:0] rem_diff;

    always_comb begin
        mul_sum  = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, md_b} : '0);
        rem_sh   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
        // The remainder stays below the divisor, so after a successful
        // compare the true difference always fits in XLEN bits.
        rem_diff = rem_sh[XLEN-1:0] - md_b;
        acc_step = {mul_sum, acc[XLEN-1:1]};
        if (l_div) begin
            // A zero divisor always "fits": quotient becomes all ones and the
            // remainder ends up equal to the dividend.
            if (rem_sh >= {1'b0, md_b})
                acc_step = {rem_diff, acc[XLEN-2:0], 1'b1};
            else
                acc_step = {rem_sh[XLEN-1:0], acc[XLEN-2:0], 1'b0};
        end
    end

    // ---------------- FSM ---------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        stall_c  = 1'b0;
        case (state)
            IDLE: begin
                if (ex.id_valid && is_md) begin
                    stall_c  = 1'b1;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                stall_c = 1'b1;
                if (cnt == LAST) state_nx = DONE;
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // ---------------- datapath registers -------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
            acc      <= '0;
            md_b     <= '0;
            cnt      <= '0;
            l_div    <= 1'b0;
            l_hi     <= 1'b0;
            l_ctrl   <= '0;
            l_store  <= '0;
            l_rd     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (ex.id_valid && is_md) begin
                        acc      <= {{XLEN{1'b0}}, fwd_a};
                        md_b     <= op_b;
                        cnt      <= '0;
                        l_div    <= ex.alu_op[2];   // 12/13 divide, 10/11 multiply
                        l_hi     <= ex.alu_op[0];   // 11 MULHU, 13 REMU
                        l_ctrl   <= {ex.mem_to_reg, ex.regwrite, ex.mem_write, ex.mem_read};
                        l_store  <= fwd_b;
                        l_rd     <= ex.rd;
                        ex_mem_q <= '0;
                    end else if (ex.id_valid) begin
                        ex_mem_q <= {ex.mem_to_reg, ex.regwrite, ex.mem_write, ex.mem_read,
                                     alu_r, fwd_b, ex.rd};
                    end else begin
                        ex_mem_q <= '0;
                    end
                end
                BUSY: begin
                    acc      <= acc_step;
                    cnt      <= cnt + 1'b1;
                    ex_mem_q <= '0;
                end
                DONE: begin
                    ex_mem_q <= {l_ctrl,
                                 l_hi ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0],
                                 l_store, l_rd};
                end
                default: ex_mem_q <= '0;
            endcase
        end
    end

    assign ex.ex_mem    = ex_mem_q;
    // Reset forces stall low even if ID/EX still presents a multiply/divide.
    assign ex.stall     = stall_c & ~rst;
    assign ex.fsm_state = state;

endmodule

// File: tb/tb_execute_stage.sv
module tb_execute_stage;
    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    execute_stage_if #(.XLEN(32)) bus ();

    execute_stage #(.XLEN(32), .MD_CYCLES(32)) dut (
        .clk (clk),
        .rst (rst),
        .ex  (bus.slave)
    );

    typedef struct {
        string       name;
        logic [3:0]  op;
        logic [4:0]  rs1;
        logic [31:0] d1;
        logic [4:0]  rs2;
        logic [31:0] d2;
        logic [31:0] imm;
        logic        use_imm;
        logic [4:0]  rd;
        logic [3:0]  ctrl;      // {mem_to_reg, regwrite, mem_write, mem_read}
        logic [4:0]  mrd;
        logic [31:0] mdata;
        logic        mwe;
        logic [4:0]  wrd;
        logic [31:0] wdata;
        logic        wwe;
        logic [31:0] exp_res;
        logic [31:0] exp_store;
    } vec_t;

    logic [72:0] exp_q[$];
    int passed = 0;
    int total  = 0;

    vec_t vecs[$];

    // ---------------- scoreboard helpers ------------------------------------
    task automatic check(input string name, input logic [72:0] act, input logic [72:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input string name, input logic [3:0] op,
                                input logic [4:0] rs1, input logic [31:0] d1,
                                input logic [4:0] rs2, input logic [31:0] d2,
                                input logic [31:0] imm, input logic use_imm,
                                input logic [4:0] rd, input logic [3:0] ctrl,
                                input logic [4:0] mrd, input logic [31:0] mdata, input logic mwe,
                                input logic [4:0] wrd, input logic [31:0] wdata, input logic wwe,
                                input logic [31:0] exp_res, input logic [31:0] exp_store);
        vec_t v;
        v.name = name; v.op = op; v.rs1 = rs1; v.d1 = d1; v.rs2 = rs2; v.d2 = d2;
        v.imm = imm; v.use_imm = use_imm; v.rd = rd; v.ctrl = ctrl;
        v.mrd = mrd; v.mdata = mdata; v.mwe = mwe;
        v.wrd = wrd; v.wdata = wdata; v.wwe = wwe;
        v.exp_res = exp_res; v.exp_store = exp_store;
        return v;
    endfunction

    // Reference for the single-cycle ops, operands already resolved.
    function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        logic [31:0] r;
        r = 32'd0;
        case (op)
            4'd0: r = a + b;
            4'd1: r = a - b;
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd4: r = a ^ b;
            4'd5: r = a << b[4:0];
            4'd6: r = a >> b[4:0];
            4'd7: begin
                r = a >> b[4:0];
                if (a[31] && b[4:0] != 5'd0) r = r | ~(32'hFFFF_FFFF >> b[4:0]);
            end
            4'd8: r = ((a[31] && !b[31]) || (a[31] == b[31] && a < b)) ? 32'd1 : 32'd0;
            4'd9: r = (a < b) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic apply(input vec_t v);
        bus.id_valid         = 1'b1;
        bus.alu_op           = v.op;
        bus.rs1              = v.rs1;
        bus.rs1_data         = v.d1;
        bus.rs2              = v.rs2;
        bus.rs2_data         = v.d2;
        bus.imm              = v.imm;
        bus.use_imm          = v.use_imm;
        bus.rd               = v.rd;
        {bus.mem_to_reg, bus.regwrite, bus.mem_write, bus.mem_read} = v.ctrl;
        bus.fwd_mem_rd       = v.mrd;
        bus.fwd_mem_data     = v.mdata;
        bus.fwd_mem_regwrite = v.mwe;
        bus.fwd_wb_rd        = v.wrd;
        bus.fwd_wb_data      = v.wdata;
        bus.fwd_wb_regwrite  = v.wwe;
    endtask

    // Drive one instruction (called at posedge+1), hold it until the stage
    // releases it, then pop and compare the emerging ex_mem bundle.
    task automatic run_op(input vec_t v);
        int  stall_cycles;
        bit  done;
        bit  was_stalled;
        logic [72:0] e;
        apply(v);
        exp_q.push_back({v.ctrl, v.exp_res, v.exp_store, v.rd});
        stall_cycles = 0;
        done = 0;
        for (int c = 0; c < 40 && !done; c++) begin
            #1;
            was_stalled = bus.stall;
            if (was_stalled) stall_cycles++;
            @(posedge clk); #1;
            if (was_stalled) begin
                if (bus.ex_mem !== 73'd0)
                    check({v.name, " bubble"}, bus.ex_mem, 73'd0);
            end else begin
                done = 1;
                if (exp_q.size() == 0) begin
                    check({v.name, " unexpected"}, bus.ex_mem, 73'd0);
                end else begin
                    e = exp_q.pop_front();
                    check(v.name, bus.ex_mem, e);
                end
            end
        end
        if (!done) check({v.name, " timeout"}, 73'd1, 73'd0);
        check({v.name, " stall_cycles"}, 73'(stall_cycles),
              (v.op >= 4'd10 && v.op <= 4'd13) ? 73'd33 : 73'd0);
    endtask

    // ---------------- test sequence ------------------------------------------
    initial begin
        vec_t v;
        bit   leaked;
        logic [31:0] ra, rb;
        logic [3:0]  rop;

        bus.id_valid = 1'b0; bus.alu_op = '0; bus.rs1 = '0; bus.rs2 = '0;
        bus.rs1_data = '0; bus.rs2_data = '0; bus.imm = '0; bus.use_imm = 1'b0;
        bus.rd = '0; bus.regwrite = 1'b0; bus.mem_to_reg = 1'b0;
        bus.mem_read = 1'b0; bus.mem_write = 1'b0;
        bus.fwd_mem_rd = '0; bus.fwd_mem_data = '0; bus.fwd_mem_regwrite = 1'b0;
        bus.fwd_wb_rd = '0; bus.fwd_wb_data = '0; bus.fwd_wb_regwrite = 1'b0;

        // Reset state
        #2;
        check("reset ex_mem", bus.ex_mem, 73'd0);
        check("reset stall", 73'(bus.stall), 73'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        check("idle bubble", bus.ex_mem, 73'd0);

        //           name        op    rs1   d1            rs2   d2            imm     ui rd    ctrl     mrd   mdata      mwe wrd  wdata          wwe exp_res        exp_store
        vecs.push_back(mk("fwd_mem_wins", 4'd0, 5'd5, 32'h55, 5'd6, 32'h1, 32'h0, 0, 5'd3, 4'b0100, 5'd5, 32'h10, 1, 5'd5, 32'h20, 1, 32'h11, 32'h1));
        vecs.push_back(mk("fwd_x0", 4'd0, 5'd0, 32'h55, 5'd6, 32'h1, 32'h0, 0, 5'd3, 4'b0100, 5'd0, 32'h10, 1, 5'd0, 32'h20, 1, 32'h56, 32'h1));
        vecs.push_back(mk("fwd_wb_only", 4'd0, 5'd5, 32'h55, 5'd6, 32'h1, 32'h0, 0, 5'd4, 4'b0100, 5'd7, 32'h10, 1, 5'd5, 32'h20, 1, 32'h21, 32'h1));
        vecs.push_back(mk("sw_store", 4'd0, 5'd1, 32'h100, 5'd2, 32'h0, 32'h8, 1, 5'd0, 4'b0010, 5'd2, 32'h77, 0, 5'd2, 32'hDEADBEEF, 1, 32'h108, 32'hDEADBEEF));
        vecs.push_back(mk("lw_ctrl", 4'd0, 5'd1, 32'h200, 5'd2, 32'h3, 32'h4, 1, 5'd8, 4'b1101, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h204, 32'h3));
        vecs.push_back(mk("sub", 4'd1, 5'd1, 32'd5, 5'd2, 32'd7, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFE, 32'd7));
        vecs.push_back(mk("and", 4'd2, 5'd1, 32'hF0F0F0F0, 5'd2, 32'hFF00FF00, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hF000F000, 32'hFF00FF00));
        vecs.push_back(mk("or", 4'd3, 5'd1, 32'hF0F0F0F0, 5'd2, 32'hFF00FF00, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFF0FFF0, 32'hFF00FF00));
        vecs.push_back(mk("xor", 4'd4, 5'd1, 32'hF0F0F0F0, 5'd2, 32'hFF00FF00, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0FF00FF0, 32'hFF00FF00));
        vecs.push_back(mk("sll_imm", 4'd5, 5'd1, 32'h1, 5'd2, 32'h5, 32'h4, 1, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h10, 32'h5));
        vecs.push_back(mk("srl", 4'd6, 5'd1, 32'h80000000, 5'd2, 32'd31, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h1, 32'd31));
        vecs.push_back(mk("sra", 4'd7, 5'd1, 32'h80000000, 5'd2, 32'd31, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFF, 32'd31));
        vecs.push_back(mk("slt", 4'd8, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h1, 32'd1));
        vecs.push_back(mk("sltu", 4'd9, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd1, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'd1));
        vecs.push_back(mk("reserved15", 4'd15, 5'd1, 32'h1234, 5'd2, 32'h99, 32'h0, 0, 5'd9, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h99));
        vecs.push_back(mk("mul", 4'd10, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd2, 32'h0, 0, 5'd10, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFE, 32'd2));
        vecs.push_back(mk("mulhu", 4'd11, 5'd1, 32'hFFFFFFFF, 5'd2, 32'd2, 32'h0, 0, 5'd11, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h1, 32'd2));
        vecs.push_back(mk("divu", 4'd12, 5'd1, 32'd100, 5'd2, 32'd7, 32'h0, 0, 5'd12, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd14, 32'd7));
        vecs.push_back(mk("remu", 4'd13, 5'd1, 32'd100, 5'd2, 32'd7, 32'h0, 0, 5'd13, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd2, 32'd7));
        vecs.push_back(mk("divu_by0", 4'd12, 5'd1, 32'd5, 5'd2, 32'd0, 32'h0, 0, 5'd14, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'hFFFFFFFF, 32'd0));
        vecs.push_back(mk("remu_by0", 4'd13, 5'd1, 32'd5, 5'd2, 32'd0, 32'h0, 0, 5'd15, 4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd5, 32'd0));
        vecs.push_back(mk("mul_fwd", 4'd10, 5'd3, 32'd1, 5'd2, 32'd1000, 32'h0, 0, 5'd16, 4'b0100, 5'd3, 32'd12345, 1, 5'd0, 32'h0, 0, 32'd12345000, 32'd1000));
        vecs.push_back(mk("reserved14", 4'd14, 5'd1, 32'h1, 5'd2, 32'h2, 32'h0, 0, 5'd17, 4'b1100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'h0, 32'h2));

        foreach (vecs[i]) run_op(vecs[i]);

        // Bubble after a real result
        bus.id_valid = 1'b0;
        @(posedge clk); #1;
        check("bubble", bus.ex_mem, 73'd0);

        // Random single-cycle ops against the reference model
        for (int i = 0; i < 12; i++) begin
            rop = 4'($urandom_range(0, 9));
            ra  = $urandom;
            rb  = $urandom;
            v = mk("rand", rop, 5'd1, ra, 5'd2, rb, 32'h0, 0, 5'($urandom_range(1, 31)),
                   4'b0100, 5'd0, 32'h0, 0, 5'd0, 32'h0, 0, ref_alu(rop, ra, rb), rb);
            run_op(v);
        end

        // Reset in the middle of a DIVU: aborts with no result
        v = mk("divu_abort", 4'd12, 5'd1, 32'd100, 5'd2, 32'd7, 32'h0, 0, 5'd20, 4'b0100,
               5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd0, 32'd0);
        apply(v);
        repeat (11) @(posedge clk);
        #1;
        check("busy before reset", 73'(bus.stall), 73'd1);
        rst = 1'b1;
        #1;
        check("abort ex_mem", bus.ex_mem, 73'd0);
        check("abort stall", 73'(bus.stall), 73'd0);
        bus.id_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        leaked = 0;
        for (int c = 0; c < 40; c++) begin
            @(posedge clk); #1;
            if (bus.ex_mem !== 73'd0 || bus.stall !== 1'b0) leaked = 1;
        end
        check("no result after abort", 73'(leaked), 73'd0);
        run_op(mk("add_after_reset", 4'd0, 5'd1, 32'd1, 5'd2, 32'd2, 32'h0, 0, 5'd21, 4'b0100,
                  5'd0, 32'h0, 0, 5'd0, 32'h0, 0, 32'd3, 32'd2));

        bus.id_valid = 1'b0;
        check("queue drained", 73'(exp_q.size()), 73'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    // Hard time limit so the bench never hangs
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d passed", passed, total);
        $fatal(1);
    end
endmodule
